// File: rtl/bp_be_long_sched.sv
// Issue-side scheduler for the iterative long-latency integer pipe: op FIFO, single-outstanding launch, rd scoreboard.
// Optional BP_BE_LONG_SCHED_PERF_EN adds busy-cycle and committed-op counters.
module bp_be_long_sched #(
    parameter int reg_addr_width_p = 5,
    parameter int payload_width_p  = 160,
    parameter int els_p            = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        req_v_i,
    input  logic [payload_width_p-1:0]  req_payload_i,
    input  logic [reg_addr_width_p-1:0] req_rd_addr_i,
    input  logic                        req_rd_w_v_i,
    output logic                        req_ready_o,
    input  logic                        flush_i,
    output logic                        unit_v_o,
    output logic [payload_width_p-1:0]  unit_payload_o,
    input  logic                        unit_ready_i,
    input  logic                        unit_done_i,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
    input  logic [reg_addr_width_p-1:0] chk_addr_i,
    output logic                        hazard_o,
    output logic                        busy_o
`ifdef BP_BE_LONG_SCHED_PERF_EN
    ,
    output logic [31:0]                 perf_busy_cycles_o,
    output logic [31:0]                 perf_ops_o
`endif
);

    // state   | meaning
    // e_idle  | no op in the unit; head of FIFO may launch
    // e_busy  | one op in the unit, its result will commit on done
    // e_drain | in-flight op was flushed; absorb its done without commit
    typedef enum logic [1:0] {e_idle, e_busy, e_drain} state_e;

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int nregs_lp = 1 << reg_addr_width_p;

    state_e                      state_q, state_d;
    logic [ptr_w_lp:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [nregs_lp-1:0]         sb_q, sb_d;
    logic [reg_addr_width_p-1:0] inflight_rd_q, inflight_rd_d;
    logic                        inflight_wv_q, inflight_wv_d;

    logic [payload_width_p-1:0]  pl_mem  [els_p-1:0];
    logic [reg_addr_width_p-1:0] rd_mem  [els_p-1:0];
    logic                        wv_mem  [els_p-1:0];

    logic empty, full, enq, launch, done_busy;
    logic [ptr_w_lp-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[ptr_w_lp-1:0];
    assign rd_idx = rd_ptr_q[ptr_w_lp-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp]) && (wr_idx == rd_idx);

    assign req_ready_o    = ~full & ~flush_i;
    assign enq            = req_v_i & req_ready_o;
    assign launch         = (state_q == e_idle) & ~empty & unit_ready_i & ~flush_i;
    assign done_busy      = (state_q == e_busy) & unit_done_i;
    assign unit_v_o       = launch;
    assign unit_payload_o = pl_mem[rd_idx];
    assign wb_v_o         = done_busy & inflight_wv_q;
    assign wb_rd_addr_o   = inflight_rd_q;
    assign hazard_o       = (chk_addr_i != '0) & sb_q[chk_addr_i];
    assign busy_o         = ~empty | (state_q != e_idle);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q + {{ptr_w_lp{1'b0}}, enq};
        rd_ptr_d      = rd_ptr_q + {{ptr_w_lp{1'b0}}, launch};
        inflight_rd_d = inflight_rd_q;
        inflight_wv_d = inflight_wv_q;
        sb_d          = sb_q;

        case (state_q)
            e_idle: if (launch) state_d = e_busy;
            // a done coincident with flush belongs to an older op, so it still commits
            e_busy: begin
                if (unit_done_i)  state_d = e_idle;
                else if (flush_i) state_d = e_drain;
            end
            e_drain: if (unit_done_i) state_d = e_idle;
            default: state_d = e_idle;
        endcase

        if (launch) begin
            inflight_rd_d = rd_mem[rd_idx];
            inflight_wv_d = wv_mem[rd_idx];
        end

        // clear before set so a same-cycle enqueue to the same rd keeps the bit
        if (done_busy && inflight_wv_q) sb_d[inflight_rd_q] = 1'b0;
        if (enq && req_rd_w_v_i && (req_rd_addr_i != '0)) sb_d[req_rd_addr_i] = 1'b1;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            sb_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= e_idle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sb_q          <= '0;
            inflight_rd_q <= '0;
            inflight_wv_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sb_q          <= sb_d;
            inflight_rd_q <= inflight_rd_d;
            inflight_wv_q <= inflight_wv_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            pl_mem[wr_idx] <= req_payload_i;
            rd_mem[wr_idx] <= req_rd_addr_i;
            wv_mem[wr_idx] <= req_rd_w_v_i;
        end
    end

`ifdef BP_BE_LONG_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d, perf_ops_q, perf_ops_d;

    always_comb begin
        perf_busy_d = perf_busy_q;
        perf_ops_d  = perf_ops_q;
        if ((state_q != e_idle) && (perf_busy_q != 32'hFFFF_FFFF)) perf_busy_d = perf_busy_q + 32'd1;
        if (wb_v_o && (perf_ops_q != 32'hFFFF_FFFF))               perf_ops_d  = perf_ops_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_busy_q <= '0;
            perf_ops_q  <= '0;
        end else begin
            perf_busy_q <= perf_busy_d;
            perf_ops_q  <= perf_ops_d;
        end
    end

    assign perf_busy_cycles_o = perf_busy_q;
    assign perf_ops_o         = perf_ops_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && (state_q == e_idle)) assert (!unit_done_i);
    end
`endif

endmodule
